turf_wb_cmd_bridge: RTL and testbench

//  Bus master feeding the TURF local WISHBONE interconnect (28-bit addr, 32-bit data).

---
 rtl/turf_wb_bridge_pkg.sv | 40 ++++
 rtl/turf_wb_cmd_bridge.sv | 187 ++++++++++++++++++
 tb/tb_turf_wb_cmd_bridge.sv | 308 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/turf_wb_bridge_pkg.sv
// ----------------------------------------------------------------------------
// turf_wb_bridge_pkg
//   Shared definitions for the TURF command-stream to WISHBONE bridge:
//   FSM state encoding, bus completion status codes, command header layout,
//   the read-failure fill word and the response header packing helper.
// ----------------------------------------------------------------------------
package turf_wb_bridge_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_GET_DATA = 3'd1,
        ST_BUS      = 3'd2,
        ST_RSP_HDR  = 3'd3,
        ST_RSP_DATA = 3'd4
    } bridge_state_t;

    typedef enum logic [1:0] {
        STATUS_OK      = 2'b00,
        STATUS_ERR     = 2'b01,
        STATUS_RTY     = 2'b10,
        STATUS_TIMEOUT = 2'b11
    } wb_status_t;

    // Command header: [31] write enable, [30:28] ignored, [27:0] address.
    localparam int unsigned HDR_WE_BIT    = 31;
    localparam int unsigned HDR_ADR_WIDTH = 28;

    // Second response word for any read that did not complete with ack.
    localparam logic [31:0] READ_FAIL_FILL = 32'hFFFF_FFFF;

    // Response word 0: {we, 1'b0, status[1:0], adr[27:0]}
    function automatic logic [31:0] pack_rsp_header(
        input logic                     we,
        input wb_status_t               status,
        input logic [HDR_ADR_WIDTH-1:0] adr
    );
        return {we, 1'b0, status, adr};
    endfunction

endpackage

// File: rtl/turf_wb_cmd_bridge.sv
// ----------------------------------------------------------------------------
// turf_wb_cmd_bridge
//   WISHBONE master for the TURF local interconnect. Consumes a 32-bit
//   command stream (header word, plus one data word for writes), runs one
//   classic single WISHBONE cycle per command and returns a two-word
//   response (header with status, then read data / write echo). A watchdog
//   terminates any bus cycle that no slave answers within TIMEOUT_CYCLES.
//
// Ports
//   clk_i, rst_i              clock, synchronous active-high reset
//   s_cmd_tdata/tvalid/tready command stream in
//   m_rsp_tdata/tvalid/tready/tlast  response stream out (tlast on word 1)
//   wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_dat_o, wb_sel_o  bus master out
//   wb_dat_i, wb_ack_i, wb_err_i, wb_rty_i                    bus slave in
// ----------------------------------------------------------------------------
module turf_wb_cmd_bridge
    import turf_wb_bridge_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH     = 28,
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned TIMEOUT_CYCLES = 1023
) (
    input  logic                    clk_i,
    input  logic                    rst_i,

    input  logic [DATA_WIDTH-1:0]   s_cmd_tdata,
    input  logic                    s_cmd_tvalid,
    output logic                    s_cmd_tready,

    output logic [DATA_WIDTH-1:0]   m_rsp_tdata,
    output logic                    m_rsp_tvalid,
    input  logic                    m_rsp_tready,
    output logic                    m_rsp_tlast,

    output logic                    wb_cyc_o,
    output logic                    wb_stb_o,
    output logic                    wb_we_o,
    output logic [ADDR_WIDTH-1:0]   wb_adr_o,
    output logic [DATA_WIDTH-1:0]   wb_dat_o,
    output logic [DATA_WIDTH/8-1:0] wb_sel_o,
    input  logic [DATA_WIDTH-1:0]   wb_dat_i,
    input  logic                    wb_ack_i,
    input  logic                    wb_err_i,
    input  logic                    wb_rty_i
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    bridge_state_t              state;
    logic [CNT_W-1:0]           timeout_cnt;
    logic [DATA_WIDTH-1:0]      rsp_word1_q;

    logic                       cmd_beat;
    logic                       bus_done;
    wb_status_t                 bus_status;
    logic [DATA_WIDTH-1:0]      rsp_word0;
    logic [DATA_WIDTH-1:0]      rsp_word1;
    logic [HDR_ADR_WIDTH-1:0]   adr_field;

    // Header bits between the address field and the we bit carry no meaning.
    logic                       unused_hdr_bits;
    assign unused_hdr_bits = ^s_cmd_tdata[DATA_WIDTH-2:ADDR_WIDTH];

    assign cmd_beat = s_cmd_tvalid && s_cmd_tready;

    // Bus termination decode; only acted upon in ST_BUS, so strobes seen in
    // any other state are ignored. Priority: err > rty > ack > timeout.
    always_comb begin
        bus_done   = 1'b0;
        bus_status = STATUS_OK;
        if (wb_err_i) begin
            bus_done   = 1'b1;
            bus_status = STATUS_ERR;
        end else if (wb_rty_i) begin
            bus_done   = 1'b1;
            bus_status = STATUS_RTY;
        end else if (wb_ack_i) begin
            bus_done   = 1'b1;
            bus_status = STATUS_OK;
        end else if (timeout_cnt == CNT_W'(TIMEOUT_CYCLES)) begin
            bus_done   = 1'b1;
            bus_status = STATUS_TIMEOUT;
        end
    end

    always_comb begin
        adr_field = HDR_ADR_WIDTH'(wb_adr_o);
        rsp_word0 = DATA_WIDTH'(pack_rsp_header(wb_we_o, bus_status, adr_field));
        if (wb_we_o) begin
            rsp_word1 = wb_dat_o;
        end else if (bus_status == STATUS_OK) begin
            rsp_word1 = wb_dat_i;
        end else begin
            rsp_word1 = DATA_WIDTH'(READ_FAIL_FILL);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state        <= ST_IDLE;
            timeout_cnt  <= '0;
            rsp_word1_q  <= '0;
            s_cmd_tready <= 1'b0;
            m_rsp_tdata  <= '0;
            m_rsp_tvalid <= 1'b0;
            m_rsp_tlast  <= 1'b0;
            wb_cyc_o     <= 1'b0;
            wb_stb_o     <= 1'b0;
            wb_we_o      <= 1'b0;
            wb_adr_o     <= '0;
            wb_dat_o     <= '0;
            wb_sel_o     <= '1;
        end else begin
            wb_sel_o <= '1;
            case (state)
                ST_IDLE: begin
                    if (cmd_beat) begin
                        wb_we_o  <= s_cmd_tdata[HDR_WE_BIT];
                        wb_adr_o <= s_cmd_tdata[ADDR_WIDTH-1:0];
                        wb_dat_o <= '0;
                        if (s_cmd_tdata[HDR_WE_BIT]) begin
                            // stay ready for the write data beat
                            state        <= ST_GET_DATA;
                            s_cmd_tready <= 1'b1;
                        end else begin
                            state        <= ST_BUS;
                            s_cmd_tready <= 1'b0;
                            wb_cyc_o     <= 1'b1;
                            wb_stb_o     <= 1'b1;
                            timeout_cnt  <= '0;
                        end
                    end else begin
                        s_cmd_tready <= 1'b1;
                    end
                end

                ST_GET_DATA: begin
                    if (cmd_beat) begin
                        wb_dat_o     <= s_cmd_tdata;
                        s_cmd_tready <= 1'b0;
                        wb_cyc_o     <= 1'b1;
                        wb_stb_o     <= 1'b1;
                        timeout_cnt  <= '0;
                        state        <= ST_BUS;
                    end
                end

                ST_BUS: begin
                    if (bus_done) begin
                        wb_cyc_o     <= 1'b0;
                        wb_stb_o     <= 1'b0;
                        m_rsp_tdata  <= rsp_word0;
                        m_rsp_tvalid <= 1'b1;
                        m_rsp_tlast  <= 1'b0;
                        rsp_word1_q  <= rsp_word1;
                        state        <= ST_RSP_HDR;
                    end else begin
                        timeout_cnt <= timeout_cnt + CNT_W'(1);
                    end
                end

                ST_RSP_HDR: begin
                    if (m_rsp_tready) begin
                        m_rsp_tdata <= rsp_word1_q;
                        m_rsp_tlast <= 1'b1;
                        state       <= ST_RSP_DATA;
                    end
                end

                ST_RSP_DATA: begin
                    if (m_rsp_tready) begin
                        m_rsp_tdata  <= '0;
                        m_rsp_tvalid <= 1'b0;
                        m_rsp_tlast  <= 1'b0;
                        s_cmd_tready <= 1'b1;
                        state        <= ST_IDLE;
                    end
                end

                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_turf_wb_cmd_bridge.sv
module tb_turf_wb_cmd_bridge;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic [31:0] s_cmd_tdata = '0;
    logic        s_cmd_tvalid = 1'b0;
    logic        s_cmd_tready;
    logic [31:0] m_rsp_tdata;
    logic        m_rsp_tvalid;
    logic        m_rsp_tready = 1'b1;
    logic        m_rsp_tlast;
    logic        wb_cyc_o;
    logic        wb_stb_o;
    logic        wb_we_o;
    logic [27:0] wb_adr_o;
    logic [31:0] wb_dat_o;
    logic [3:0]  wb_sel_o;
    logic [31:0] wb_dat_i = '0;
    logic        wb_ack_i = 1'b0;
    logic        wb_err_i = 1'b0;
    logic        wb_rty_i = 1'b0;

    int n_checks = 0;
    int n_fail   = 0;

    turf_wb_cmd_bridge #(
        .ADDR_WIDTH    (28),
        .DATA_WIDTH    (32),
        .TIMEOUT_CYCLES(15)
    ) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .s_cmd_tdata  (s_cmd_tdata),
        .s_cmd_tvalid (s_cmd_tvalid),
        .s_cmd_tready (s_cmd_tready),
        .m_rsp_tdata  (m_rsp_tdata),
        .m_rsp_tvalid (m_rsp_tvalid),
        .m_rsp_tready (m_rsp_tready),
        .m_rsp_tlast  (m_rsp_tlast),
        .wb_cyc_o     (wb_cyc_o),
        .wb_stb_o     (wb_stb_o),
        .wb_we_o      (wb_we_o),
        .wb_adr_o     (wb_adr_o),
        .wb_dat_o     (wb_dat_o),
        .wb_sel_o     (wb_sel_o),
        .wb_dat_i     (wb_dat_i),
        .wb_ack_i     (wb_ack_i),
        .wb_err_i     (wb_err_i),
        .wb_rty_i     (wb_rty_i)
    );

    always #5 clk_i = ~clk_i;

    // All stimulus changes and samples happen just after the falling edge.

    // Present one command beat; returns at the negedge after its handshake.
    task automatic send_beat(input logic [31:0] d, output bit ok);
        ok = 1'b0;
        s_cmd_tdata  = d;
        s_cmd_tvalid = 1'b1;
        for (int i = 0; i < 50; i++) begin
            if (s_cmd_tready === 1'b1) begin
                ok = 1'b1;
                @(negedge clk_i);
                break;
            end
            @(negedge clk_i);
        end
        s_cmd_tvalid = 1'b0;
        s_cmd_tdata  = '0;
    endtask

    // Collect a two-word response with tready held high.
    task automatic recv_rsp(output logic [31:0] w0, output logic l0,
                            output logic [31:0] w1, output logic l1,
                            output bit ok);
        bit got;
        ok = 1'b0; w0 = '0; w1 = '0; l0 = 1'b0; l1 = 1'b0;
        m_rsp_tready = 1'b1;
        got = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (m_rsp_tvalid === 1'b1) begin
                w0 = m_rsp_tdata; l0 = m_rsp_tlast; got = 1'b1;
                break;
            end
            @(negedge clk_i);
        end
        if (got) begin
            @(negedge clk_i);
            if (m_rsp_tvalid === 1'b1) begin
                w1 = m_rsp_tdata; l1 = m_rsp_tlast; ok = 1'b1;
            end
            @(negedge clk_i);
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk_i);
        rst_i = 1'b0;
        n_checks++;
        if ({wb_cyc_o, wb_stb_o, wb_we_o, m_rsp_tvalid, m_rsp_tlast, s_cmd_tready} !== 6'b0) begin
            n_fail++;
            $display("FAIL reset_ctrl: got cyc=%b stb=%b we=%b tvalid=%b tlast=%b tready=%b expected all 0",
                     wb_cyc_o, wb_stb_o, wb_we_o, m_rsp_tvalid, m_rsp_tlast, s_cmd_tready);
        end
        n_checks++;
        if ({wb_adr_o, wb_dat_o, m_rsp_tdata} !== '0) begin
            n_fail++;
            $display("FAIL reset_data: got adr=%h dat=%h rsp=%h expected 0", wb_adr_o, wb_dat_o, m_rsp_tdata);
        end
        n_checks++;
        if (wb_sel_o !== 4'hF) begin
            n_fail++;
            $display("FAIL reset_sel: got %h expected f", wb_sel_o);
        end
        @(negedge clk_i);
        n_checks++;
        if (s_cmd_tready !== 1'b1) begin
            n_fail++;
            $display("FAIL idle_tready: got %b expected 1", s_cmd_tready);
        end
    endtask

    task automatic test_read_ack();
        bit ok; int ncyc; logic [31:0] w0, w1; logic l0, l1;
        send_beat(32'h0000_8004, ok);
        n_checks++;
        if (ok !== 1'b1) begin n_fail++; $display("FAIL rd_hdr_accept: got %b expected 1", ok); end
        n_checks++;
        if ({wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_dat_o, wb_sel_o} !== {1'b1, 1'b1, 1'b0, 28'h0008004, 32'h0, 4'hF}) begin
            n_fail++;
            $display("FAIL rd_bus: got cyc=%b stb=%b we=%b adr=%h dat=%h sel=%h expected 1 1 0 0008004 00000000 f",
                     wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_dat_o, wb_sel_o);
        end
        ncyc = 0;
        for (int k = 0; k < 20; k++) begin
            if (wb_cyc_o !== 1'b1) break;
            ncyc++;
            wb_ack_i = (ncyc == 3);
            wb_dat_i = (ncyc == 3) ? 32'h1234_5678 : 32'h0;
            @(negedge clk_i);
        end
        wb_ack_i = 1'b0; wb_dat_i = '0;
        n_checks++;
        if (ncyc != 3) begin n_fail++; $display("FAIL rd_cyc_len: got %0d expected 3", ncyc); end
        n_checks++;
        if (s_cmd_tready !== 1'b0) begin n_fail++; $display("FAIL rd_busy_tready: got %b expected 0", s_cmd_tready); end
        recv_rsp(w0, l0, w1, l1, ok);
        n_checks++;
        if ({ok, w0, l0, w1, l1} !== {1'b1, 32'h0000_8004, 1'b0, 32'h1234_5678, 1'b1}) begin
            n_fail++;
            $display("FAIL rd_rsp: got ok=%b %h/%b %h/%b expected 1 00008004/0 12345678/1", ok, w0, l0, w1, l1);
        end
        n_checks++;
        if ({m_rsp_tvalid, s_cmd_tready} !== 2'b01) begin
            n_fail++;
            $display("FAIL rd_after: got tvalid=%b tready=%b expected 0 1", m_rsp_tvalid, s_cmd_tready);
        end
    endtask

    task automatic test_write();
        bit ok; logic [31:0] w0, w1; logic l0, l1;
        send_beat(32'h8001_8010, ok);
        n_checks++;
        if ({ok, s_cmd_tready, wb_cyc_o} !== 3'b110) begin
            n_fail++;
            $display("FAIL wr_hdr: got ok=%b tready=%b cyc=%b expected 1 1 0", ok, s_cmd_tready, wb_cyc_o);
        end
        send_beat(32'hCAFE_F00D, ok);
        n_checks++;
        if ({ok, wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_dat_o} !== {4'b1111, 28'h0018010, 32'hCAFE_F00D}) begin
            n_fail++;
            $display("FAIL wr_bus: got ok=%b cyc=%b stb=%b we=%b adr=%h dat=%h expected 1 1 1 1 0018010 cafef00d",
                     ok, wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_dat_o);
        end
        wb_ack_i = 1'b1; wb_dat_i = 32'h1111_2222;
        @(negedge clk_i);
        wb_ack_i = 1'b0; wb_dat_i = '0;
        n_checks++;
        if (wb_cyc_o !== 1'b0) begin n_fail++; $display("FAIL wr_cyc_drop: got %b expected 0", wb_cyc_o); end
        recv_rsp(w0, l0, w1, l1, ok);
        n_checks++;
        if ({ok, w0, l0, w1, l1} !== {1'b1, 32'h8001_8010, 1'b0, 32'hCAFE_F00D, 1'b1}) begin
            n_fail++;
            $display("FAIL wr_rsp: got ok=%b %h/%b %h/%b expected 1 80018010/0 cafef00d/1", ok, w0, l0, w1, l1);
        end
    endtask

    task automatic test_timeout();
        bit ok; int ncyc; logic [31:0] w0, w1; logic l0, l1;
        send_beat(32'h0002_0004, ok);
        ncyc = 0;
        for (int k = 0; k < 40; k++) begin
            if (wb_cyc_o !== 1'b1) break;
            ncyc++;
            @(negedge clk_i);
        end
        n_checks++;
        if (ncyc != 16) begin n_fail++; $display("FAIL to_cyc_len: got %0d expected 16", ncyc); end
        recv_rsp(w0, l0, w1, l1, ok);
        n_checks++;
        if ({ok, w0, l0, w1, l1} !== {1'b1, 32'h3002_0004, 1'b0, 32'hFFFF_FFFF, 1'b1}) begin
            n_fail++;
            $display("FAIL to_rsp: got ok=%b %h/%b %h/%b expected 1 30020004/0 ffffffff/1", ok, w0, l0, w1, l1);
        end
    endtask

    // Single-cycle termination with several strobes together; checks priority.
    task automatic test_priority(input logic [27:0] adr, input logic ack, input logic err,
                                 input logic rty, input logic [31:0] exp_w0, input logic [31:0] exp_w1);
        bit ok; logic [31:0] w0, w1; logic l0, l1;
        send_beat({4'h0, adr}, ok);
        wb_ack_i = ack; wb_err_i = err; wb_rty_i = rty; wb_dat_i = 32'hDEAD_BEEF;
        @(negedge clk_i);
        wb_ack_i = 1'b0; wb_err_i = 1'b0; wb_rty_i = 1'b0; wb_dat_i = '0;
        recv_rsp(w0, l0, w1, l1, ok);
        n_checks++;
        if ({ok, w0, l0, w1, l1} !== {1'b1, exp_w0, 1'b0, exp_w1, 1'b1}) begin
            n_fail++;
            $display("FAIL prio_%0b%0b%0b: got ok=%b %h/%b %h/%b expected 1 %h/0 %h/1",
                     ack, err, rty, ok, w0, l0, w1, l1, exp_w0, exp_w1);
        end
    endtask

    task automatic test_backpressure();
        bit ok; logic [31:0] w0, w1; logic l0, l1;
        m_rsp_tready = 1'b0;
        send_beat(32'h0000_0040, ok);
        wb_ack_i = 1'b1; wb_dat_i = 32'h55AA_55AA;
        @(negedge clk_i);
        wb_ack_i = 1'b0; wb_dat_i = '0;
        s_cmd_tdata = 32'h0000_0100; s_cmd_tvalid = 1'b1;
        for (int k = 0; k < 10; k++) begin
            n_checks++;
            if ({m_rsp_tvalid, m_rsp_tdata, m_rsp_tlast} !== {1'b1, 32'h0000_0040, 1'b0}) begin
                n_fail++;
                $display("FAIL bp_hold[%0d]: got tvalid=%b data=%h tlast=%b expected 1 00000040 0",
                         k, m_rsp_tvalid, m_rsp_tdata, m_rsp_tlast);
            end
            n_checks++;
            if ({s_cmd_tready, wb_cyc_o} !== 2'b00) begin
                n_fail++;
                $display("FAIL bp_idle[%0d]: got tready=%b cyc=%b expected 0 0", k, s_cmd_tready, wb_cyc_o);
            end
            @(negedge clk_i);
        end
        s_cmd_tvalid = 1'b0; s_cmd_tdata = '0;
        recv_rsp(w0, l0, w1, l1, ok);
        n_checks++;
        if ({ok, w0, l0, w1, l1} !== {1'b1, 32'h0000_0040, 1'b0, 32'h55AA_55AA, 1'b1}) begin
            n_fail++;
            $display("FAIL bp_rsp: got ok=%b %h/%b %h/%b expected 1 00000040/0 55aa55aa/1", ok, w0, l0, w1, l1);
        end
    endtask

    task automatic test_reset_mid_cycle();
        bit ok; logic [31:0] w0, w1; logic l0, l1;
        send_beat(32'h0000_0ABC, ok);
        @(negedge clk_i);
        n_checks++;
        if (wb_cyc_o !== 1'b1) begin n_fail++; $display("FAIL rst_pre_cyc: got %b expected 1", wb_cyc_o); end
        rst_i = 1'b1;
        @(negedge clk_i);
        rst_i = 1'b0;
        n_checks++;
        if ({wb_cyc_o, wb_stb_o, m_rsp_tvalid} !== 3'b000) begin
            n_fail++;
            $display("FAIL rst_abort: got cyc=%b stb=%b tvalid=%b expected 0 0 0", wb_cyc_o, wb_stb_o, m_rsp_tvalid);
        end
        // Stray terminations after the abort must not produce a response.
        wb_ack_i = 1'b1; wb_err_i = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk_i);
            n_checks++;
            if ({m_rsp_tvalid, wb_cyc_o} !== 2'b00) begin
                n_fail++;
                $display("FAIL rst_no_rsp[%0d]: got tvalid=%b cyc=%b expected 0 0", k, m_rsp_tvalid, wb_cyc_o);
            end
        end
        wb_ack_i = 1'b0; wb_err_i = 1'b0;
        send_beat(32'h0000_8004, ok);
        wb_ack_i = 1'b1; wb_dat_i = 32'h0BAD_F00D;
        @(negedge clk_i);
        wb_ack_i = 1'b0; wb_dat_i = '0;
        recv_rsp(w0, l0, w1, l1, ok);
        n_checks++;
        if ({ok, w0, l0, w1, l1} !== {1'b1, 32'h0000_8004, 1'b0, 32'h0BAD_F00D, 1'b1}) begin
            n_fail++;
            $display("FAIL rst_next_rsp: got ok=%b %h/%b %h/%b expected 1 00008004/0 0badf00d/1", ok, w0, l0, w1, l1);
        end
    endtask

    initial begin
        @(negedge clk_i);
        test_reset();
        test_read_ack();
        test_write();
        test_timeout();
        test_priority(28'h0010000, 1'b1, 1'b1, 1'b0, 32'h1001_0000, 32'hFFFF_FFFF);
        test_priority(28'h0000ABC, 1'b1, 1'b0, 1'b1, 32'h2000_0ABC, 32'hFFFF_FFFF);
        test_priority(28'h0000ABC, 1'b0, 1'b1, 1'b1, 32'h1000_0ABC, 32'hFFFF_FFFF);
        test_backpressure();
        test_reset_mid_cycle();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
